// File: rtl/sakuya_if_pkg.sv
// ============================================================================
// sakuya_if_pkg : shared FSM encodings and sizing helpers for the device IF.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package sakuya_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } rx_state_e;

    // Width of a counter able to index every cycle of a conversion frame.
    function automatic int frame_cnt_w(input int frame);
        return (frame > 2) ? $clog2(frame) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_rx_if_if.sv
// ============================================================================
// adc_rx_if_if : sample output handshake bundle of the ADC receive interface.
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface adc_rx_if_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
    logic              clr_ovr;

    modport master (
        output sample, sample_valid, overrun,
        input  sample_ready, clr_ovr
    );

    modport slave (
        input  sample, sample_valid, overrun,
        output sample_ready, clr_ovr
    );
endinterface

`default_nettype wire

// File: rtl/adc_rx_shift.sv
// ============================================================================
// adc_rx_shift : LSB-first serial deserializer with bit counter and done pulse.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module adc_rx_shift #(
    parameter int DWIDTH = 8
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               shift_en_i,
    input  wire               din_i,
    output logic              done_o,
    output logic [DWIDTH-1:0] word_o
);
    localparam int                CW   = $clog2(DWIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(DWIDTH - 1);

    logic [CW-1:0]     bit_cnt_q;
    logic [DWIDTH-1:0] shreg_q;

    // word_o already includes the bit being sampled, so it is complete with done_o.
    assign done_o = shift_en_i && (bit_cnt_q == c_LAST);
    assign word_o = {din_i, shreg_q[DWIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else if (shift_en_i) begin
            shreg_q   <= word_o;
            bit_cnt_q <= done_o ? '0 : bit_cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_rx_if.sv
// ============================================================================
// adc_rx_if : serial ADC capture FSM with valid/ready output register.
//             Define ADCRX_AVG_EN to average 2**AVG_LOG2 frames per word.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module adc_rx_if
    import sakuya_if_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int FRAME    = 10,
    parameter int AVG_LOG2 = 2
) (
    input  wire          dclk,
    input  wire          rst,
    input  wire          en,
    input  wire          din,
    output logic         dce_n,
    adc_rx_if_if.master  bus
);
    localparam int FCW      = frame_cnt_w(FRAME);
    localparam int WAIT_CYC = FRAME - 1 - DWIDTH;
    localparam logic [FCW-1:0] c_WAIT_LAST = (WAIT_CYC > 0) ? FCW'(WAIT_CYC - 1) : '0;

    if (DWIDTH < 2 || FRAME < DWIDTH + 1 || AVG_LOG2 < 0) begin : g_param_chk
        $error("adc_rx_if: illegal parameter combination");
    end

    rx_state_e         state_q;
    logic              dce_n_q;
    logic [FCW-1:0]    wait_cnt_q;
    logic [DWIDTH-1:0] sample_q;
    logic              sample_valid_q;
    logic              overrun_q;

    logic              w_done;
    logic [DWIDTH-1:0] w_word;
    logic              w_load;
    logic [DWIDTH-1:0] w_load_word;

    adc_rx_shift #(.DWIDTH(DWIDTH)) u_shift (
        .clk        (dclk),
        .rst        (rst),
        .shift_en_i (state_q == ST_SHIFT),
        .din_i      (din),
        .done_o     (w_done),
        .word_o     (w_word)
    );

    always_ff @(posedge dclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dce_n_q    <= 1'b1;
            wait_cnt_q <= '0;
        end else begin
            dce_n_q    <= 1'b1;
            wait_cnt_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_CONV;
                        dce_n_q <= 1'b0;
                    end
                end
                ST_CONV: state_q <= ST_SHIFT;
                ST_SHIFT: begin
                    if (w_done) begin
                        if (WAIT_CYC > 0) begin
                            state_q <= ST_WAIT;
                        end else if (en) begin
                            state_q <= ST_CONV;
                            dce_n_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == c_WAIT_LAST) begin
                        if (en) begin
                            state_q <= ST_CONV;
                            dce_n_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ADCRX_AVG_EN
    localparam int AW = DWIDTH + AVG_LOG2;

    logic [AW-1:0]       acc_q;
    logic [AVG_LOG2-1:0] blk_cnt_q;
    logic [AW-1:0]       w_sum;

    assign w_sum       = acc_q + AW'(w_word);
    assign w_load      = w_done && (blk_cnt_q == '1);
    assign w_load_word = w_sum[AW-1:AVG_LOG2];

    // Restarting from IDLE drops any partial block left by a previous burst.
    always_ff @(posedge dclk) begin
        if (rst || (state_q == ST_IDLE && en)) begin
            acc_q     <= '0;
            blk_cnt_q <= '0;
        end else if (w_done) begin
            acc_q     <= w_load ? '0 : w_sum;
            blk_cnt_q <= blk_cnt_q + 1'b1;
        end
    end
`else
    assign w_load      = w_done;
    assign w_load_word = w_word;
`endif

    always_ff @(posedge dclk) begin
        if (rst) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            if (w_load && (!sample_valid_q || bus.sample_ready)) begin
                sample_q       <= w_load_word;
                sample_valid_q <= 1'b1;
            end else if (sample_valid_q && bus.sample_ready) begin
                sample_valid_q <= 1'b0;
            end

            if (w_load && sample_valid_q && !bus.sample_ready) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign dce_n            = dce_n_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_rx_if.sv
// ============================================================================
// tb_adc_rx_if : self-checking bench for adc_rx_if (DWIDTH=8, FRAME=10).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_adc_rx_if;
    localparam int DW = 8;
    localparam int FR = 10;

    typedef struct {
        logic [7:0] din_word;
        logic [7:0] exp_sample;
    } vec_t;

    logic dclk = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic din  = 1'b0;
    logic dce_n;

    adc_rx_if_if #(.DWIDTH(DW)) bus ();

    adc_rx_if #(.DWIDTH(DW), .FRAME(FR), .AVG_LOG2(2)) dut (
        .dclk  (dclk),
        .rst   (rst),
        .en    (en),
        .din   (din),
        .dce_n (dce_n),
        .bus   (bus)
    );

    always #5 dclk = ~dclk;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_hs = 0;
    int         last_hs_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] tx_word;
    logic [7:0] exp_word;

    always @(posedge dclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // ADC model: after each strobe, present the next word LSB-first after each edge.
    always begin
        @(negedge dclk);
        if (dce_n === 1'b0) begin
            tx_word = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
            for (int i = 0; i < DW; i++) begin
                @(posedge dclk);
                #1 din = tx_word[i];
            end
        end
    end

    // Scoreboard: every accepted word must match the oldest expected entry.
    always @(negedge dclk) begin
        if (!rst && bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) begin
            n_hs++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL handshake_unexpected: got 0x%0h, required no word", bus.sample);
            end else begin
                exp_word = exp_q.pop_front();
                chk("handshake_word", {24'h0, bus.sample}, {24'h0, exp_word});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge dclk);
            #1;
        end
    endtask

    task automatic wait_dce(output int c);
        c = -1;
        for (int k = 0; k < 4 * FR; k++) begin
            @(negedge dclk);
            if (dce_n === 1'b0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_dce: got no strobe, required one within %0d cycles", 4 * FR);
        end
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int k = 0; k < 4 * FR; k++) begin
            @(negedge dclk);
            if (bus.sample_valid === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_valid: got no valid, required one within %0d cycles", 4 * FR);
        end
    endtask

    task automatic run_frames(input int n);
        int c;
        en = 1'b1;
        for (int f = 0; f < n; f++) wait_dce(c);
        en = 1'b0;
        tick(FR + 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   c0, c1, c2, hs0, lows;

        bus.sample_ready = 1'b0;
        bus.clr_ovr      = 1'b0;
        tick(3);
        @(negedge dclk);
        chk("reset_dce_n",   {31'h0, dce_n},            32'h1);
        chk("reset_valid",   {31'h0, bus.sample_valid}, 32'h0);
        chk("reset_sample",  {24'h0, bus.sample},       32'h0);
        chk("reset_overrun", {31'h0, bus.overrun},      32'h0);
        tick(1);
        rst = 1'b0;
        tick(2);

`ifdef ADCRX_AVG_EN
        bus.sample_ready = 1'b1;
        tx_q = '{8'h10, 8'h20, 8'h30, 8'h41};
        exp_q.push_back(8'h28);
        hs0 = n_hs;
        en  = 1'b1;
        wait_dce(c0);
        wait_dce(c1);
        wait_dce(c1);
        wait_dce(c1);
        en = 1'b0;
        tick(FR + 3);
        chk("avg_count",   n_hs - hs0,          32'd1);
        chk("avg_latency", last_hs_cyc - c0,    32'd39);
        chk("avg_sample",  {24'h0, bus.sample}, 32'h28);
        chk("avg_drained", exp_q.size(),        32'd0);

        tx_q = '{8'h40, 8'h40};
        hs0  = n_hs;
        run_frames(2);
        chk("avg_partial_dropped", n_hs - hs0, 32'd0);

        tx_q = '{8'h04, 8'h08, 8'h0C, 8'h10};
        exp_q.push_back(8'h0A);
        hs0 = n_hs;
        run_frames(4);
        chk("avg2_count",  n_hs - hs0,          32'd1);
        chk("avg2_sample", {24'h0, bus.sample}, 32'h0A);
`else
        // Basic capture timing.
        bus.sample_ready = 1'b1;
        tx_q  = '{8'hA5, 8'h3C};
        exp_q = '{8'hA5, 8'h3C};
        en = 1'b1;
        wait_dce(c0);
        @(negedge dclk);
        chk("conv_one_cycle", {31'h0, dce_n}, 32'h1);
        wait_valid(c1);
        chk("valid_latency", c1 - c0, 32'd9);
        wait_dce(c2);
        chk("frame_period", c2 - c0, 32'd10);
        en = 1'b0;
        tick(FR + 3);
        chk("basic_drained", exp_q.size(), 32'd0);

        // Table of single-frame captures.
        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'hFF, 8'hFF};
        vecs[2] = '{8'h01, 8'h01};
        vecs[3] = '{8'h80, 8'h80};
        vecs[4] = '{8'h5A, 8'h5A};
        vecs[5] = '{8'hC3, 8'hC3};
        vecs[6] = '{8'h7E, 8'h7E};
        for (int i = 0; i < 7; i++) begin
            tx_q.push_back(vecs[i].din_word);
            exp_q.push_back(vecs[i].exp_sample);
            hs0 = n_hs;
            run_frames(1);
            chk("table_sample", {24'h0, bus.sample}, {24'h0, vecs[i].exp_sample});
            chk("table_count",  n_hs - hs0,          32'd1);
        end

        // Back-pressure: second word dropped, overrun set, then cleared.
        bus.sample_ready = 1'b0;
        tx_q = '{8'h11, 8'h22};
        exp_q.push_back(8'h11);
        run_frames(2);
        @(negedge dclk);
        chk("bp_sample",  {24'h0, bus.sample},       32'h11);
        chk("bp_valid",   {31'h0, bus.sample_valid}, 32'h1);
        chk("bp_overrun", {31'h0, bus.overrun},      32'h1);
        tick(1);
        bus.clr_ovr = 1'b1;
        tick(1);
        bus.clr_ovr = 1'b0;
        @(negedge dclk);
        chk("clr_overrun", {31'h0, bus.overrun}, 32'h0);
        bus.sample_ready = 1'b1;
        tick(1);
        bus.sample_ready = 1'b0;
        tick(2);

        // Consume of 0x22 coincides with completion of 0x33.
        tx_q  = '{8'h22, 8'h33};
        exp_q = '{8'h22, 8'h33};
        en = 1'b1;
        wait_dce(c0);
        wait_dce(c2);
        en = 1'b0;
        tick(8);
        bus.sample_ready = 1'b1;
        tick(1);
        bus.sample_ready = 1'b0;
        @(negedge dclk);
        chk("simul_sample",  {24'h0, bus.sample},       32'h33);
        chk("simul_valid",   {31'h0, bus.sample_valid}, 32'h1);
        chk("simul_overrun", {31'h0, bus.overrun},      32'h0);
        tick(1);
        bus.sample_ready = 1'b1;
        tick(1);
        tick(FR);
        chk("simul_drained", exp_q.size(), 32'd0);

        // en dropped during bit 3: frame still completes, then idle.
        tx_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        hs0 = n_hs;
        en  = 1'b1;
        wait_dce(c0);
        tick(4);
        en = 1'b0;
        tick(FR);
        chk("endrop_count",  n_hs - hs0,          32'd1);
        chk("endrop_sample", {24'h0, bus.sample}, 32'h5A);
        lows = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            @(negedge dclk);
            if (dce_n !== 1'b1) lows++;
        end
        chk("endrop_idle", lows, 32'd0);

        // Reset during bit 5 abandons the word.
        tx_q.push_back(8'h77);
        hs0 = n_hs;
        en  = 1'b1;
        wait_dce(c0);
        tick(6);
        rst = 1'b1;
        en  = 1'b0;
        tick(1);
        rst = 1'b0;
        @(negedge dclk);
        chk("rst_dce_n",  {31'h0, dce_n},            32'h1);
        chk("rst_valid",  {31'h0, bus.sample_valid}, 32'h0);
        chk("rst_sample", {24'h0, bus.sample},       32'h0);
        tick(3 * FR);
        chk("rst_no_word", n_hs - hs0, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
